// File: rtl/ser_pkg.sv
// Shared types for the serial packer: FSM state encoding and word type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ser_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/ser_fifo.sv
// Small synchronous FIFO holding whole words ahead of the serialiser.
// Latency: a pushed word is visible at dout/empty one edge after the push.
// Backpressure: full is a flop; callers must gate push with !full. Flush wins over push/pop.
module ser_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic         empty_nxt,
    output logic [W-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    // Next pointers and occupancy; a flush empties everything at once.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    // Pointer, count and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Word storage; contents need no reset because empty guards every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign empty_nxt = empty_d;
    assign dout      = mem_q[rd_ptr_q];

endmodule

// File: rtl/ser_tx_packer.sv
// Buffers parallel words and serialises each onto rx_data/rx_val, tagging bits with a word index.
// Latency: push at edge t0 into an idle, empty packer gives the first bit in the cycle after t0+1.
// Backpressure: in_ready = !full of the input FIFO; the serial side is never stalled.
module ser_tx_packer
    import ser_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              rx_data,
    output logic              rx_val,
    output logic [31:0]       index,
    output logic              busy
);

    localparam int BCW = $clog2(DATA_W);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    word_t             next_index_q, next_index_d;
    word_t             index_q, index_d;
    logic              rx_data_q, rx_data_d;
    logic              rx_val_q, rx_val_d;
    logic              busy_q, busy_d;

    logic              fifo_full, fifo_empty, fifo_empty_nxt;
    logic [DATA_W-1:0] fifo_dout;
    logic              push, pop, load;

    assign push = in_valid && !fifo_full;

    ser_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .din       (in_data),
        .pop       (pop),
        .flush     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt),
        .dout      (fifo_dout)
    );

    // Serialiser next state: shift a bit per cycle, insert gaps, reload from the FIFO head.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        next_index_d = next_index_q;
        index_d      = index_q;
        rx_data_d    = rx_data_q;
        rx_val_d     = rx_val_q;
        pop          = 1'b0;
        load         = 1'b0;

        if (flush) begin
            state_d   = IDLE;
            rx_val_d  = 1'b0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) load = 1'b1;
                end
                SHIFT: begin
                    if (bit_cnt_q == BCW'(DATA_W - 1)) begin
                        if (GAP_CYCLES > 0) begin
                            state_d   = GAP;
                            rx_val_d  = 1'b0;
                            gap_cnt_d = '0;
                        end else if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            rx_val_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (MSB_FIRST != 0) begin
                            rx_data_d = sr_q[DATA_W-1];
                            sr_d      = sr_q << 1;
                        end else begin
                            rx_data_d = sr_q[0];
                            sr_d      = sr_q >> 1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                        if (!fifo_empty) load = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    rx_val_d = 1'b0;
                end
            endcase

            // Pop the head, put its first bit on the wire and claim the next index.
            if (load) begin
                pop          = 1'b1;
                state_d      = SHIFT;
                rx_val_d     = 1'b1;
                bit_cnt_d    = '0;
                index_d      = next_index_q;
                next_index_d = next_index_q + 32'd1;
                if (MSB_FIRST != 0) begin
                    rx_data_d = fifo_dout[DATA_W-1];
                    sr_d      = fifo_dout << 1;
                end else begin
                    rx_data_d = fifo_dout[0];
                    sr_d      = fifo_dout >> 1;
                end
            end
        end

        busy_d = (state_d != IDLE) || !fifo_empty_nxt;
    end

    // All serialiser state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            next_index_q <= '0;
            index_q      <= '0;
            rx_data_q    <= 1'b0;
            rx_val_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            next_index_q <= next_index_d;
            index_q      <= index_d;
            rx_data_q    <= rx_data_d;
            rx_val_q     <= rx_val_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready = !fifo_full;
    assign rx_data  = rx_data_q;
    assign rx_val   = rx_val_q;
    assign index    = index_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ser_tx_packer.sv
// Directed bench: instance a is MSB-first with no gap, instance b is LSB-first with 3 gap cycles.
// Inputs are driven and outputs sampled on the falling edge.
// Every comparison goes through chk().
module tb_ser_tx_packer;

    logic        clk;
    logic        rst;

    logic [31:0] in_data_a, in_data_b;
    logic        in_valid_a, in_valid_b;
    logic        in_ready_a, in_ready_b;
    logic        flush_a, flush_b;
    logic        rx_data_a, rx_data_b;
    logic        rx_val_a, rx_val_b;
    logic [31:0] index_a, index_b;
    logic        busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ser_tx_packer #(.DATA_W(32), .MSB_FIRST(1), .FIFO_DEPTH(2), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .flush(flush_a), .rx_data(rx_data_a), .rx_val(rx_val_a), .index(index_a), .busy(busy_a)
    );

    ser_tx_packer #(.DATA_W(32), .MSB_FIRST(0), .FIFO_DEPTH(2), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .flush(flush_b), .rx_data(rx_data_b), .rx_val(rx_val_b), .index(index_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic val_of(input int w);
        return (w == 0) ? rx_val_a : rx_val_b;
    endfunction
    function automatic logic dat_of(input int w);
        return (w == 0) ? rx_data_a : rx_data_b;
    endfunction
    function automatic logic [31:0] idx_of(input int w);
        return (w == 0) ? index_a : index_b;
    endfunction
    function automatic logic rdy_of(input int w);
        return (w == 0) ? in_ready_a : in_ready_b;
    endfunction

    // Offer one word from a falling edge; returns on the falling edge after acceptance.
    task automatic push_word(input int w, input logic [31:0] d);
        logic r;
        int   ok;
        ok = 0;
        if (w == 0) begin in_data_a = d; in_valid_a = 1'b1; end
        else        begin in_data_b = d; in_valid_b = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            r = rdy_of(w);
            @(posedge clk);
            if (r) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        if (w == 0) in_valid_a = 1'b0; else in_valid_b = 1'b0;
        chk("push_accepted", 64'(ok), 64'd1);
    endtask

    task automatic push3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        push_word(0, a);
        push_word(0, b);
        push_word(0, c);
        chk("in_ready_low_when_full", 64'(in_ready_a), 64'd0);
        chk("busy_when_full", 64'(busy_a), 64'd1);
    endtask

    // Returns at the first falling edge with rx_val high, checking the current one first.
    task automatic wait_first(input int w, output int lat);
        lat = 0;
        while (!val_of(w) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Collects 32 bits: the first at the current falling edge, then one per falling edge.
    task automatic burst(input int w, input bit msb, output logic [31:0] word,
                         output logic [31:0] idx, output int nval, output int idx_bad);
        nval    = 0;
        idx_bad = 0;
        word    = '0;
        idx     = idx_of(w);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            if (val_of(w)) nval++;
            if (idx_of(w) !== idx) idx_bad++;
            if (msb) word = {word[30:0], dat_of(w)};
            else     word = {dat_of(w), word[31:1]};
        end
    endtask

    logic [31:0] wv [3];
    logic [31:0] iv [3];
    int          nv [3];
    int          ib [3];
    int          lat, gap, stray;

    initial begin
        rst = 1'b0;
        in_data_a = '0; in_valid_a = 1'b0; flush_a = 1'b0;
        in_data_b = '0; in_valid_b = 1'b0; flush_b = 1'b0;

        // Reset values
        #2;
        chk("rst_rx_data", 64'(rx_data_a), 64'd0);
        chk("rst_rx_val", 64'(rx_val_a), 64'd0);
        chk("rst_index", 64'(index_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // Single word, MSB first
        @(negedge clk);
        in_data_a = 32'hA5A5_0001; in_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a = 1'b0;
        chk("t1_val_before_pop", 64'(rx_val_a), 64'd0);
        chk("t1_busy_queued", 64'(busy_a), 64'd1);
        wait_first(0, lat);
        chk("t1_latency", 64'(lat), 64'd1);
        burst(0, 1'b1, wv[0], iv[0], nv[0], ib[0]);
        chk("t1_word", 64'(wv[0]), 64'hA5A5_0001);
        chk("t1_index", 64'(iv[0]), 64'd0);
        chk("t1_nval", 64'(nv[0]), 64'd32);
        chk("t1_index_const", 64'(ib[0]), 64'd0);
        @(negedge clk);
        chk("t1_val_after", 64'(rx_val_a), 64'd0);
        chk("t1_busy_after", 64'(busy_a), 64'd0);

        // Three back-to-back words, no bubble
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fork
            push3(32'h1, 32'h2, 32'h3);
            begin
                wait_first(0, lat);
                burst(0, 1'b1, wv[0], iv[0], nv[0], ib[0]);
                @(negedge clk);
                burst(0, 1'b1, wv[1], iv[1], nv[1], ib[1]);
                @(negedge clk);
                burst(0, 1'b1, wv[2], iv[2], nv[2], ib[2]);
            end
        join
        chk("t2_latency", 64'(lat), 64'd2);
        for (int k = 0; k < 3; k++) begin
            chk("t2_word", 64'(wv[k]), 64'(k + 1));
            chk("t2_index", 64'(iv[k]), 64'(k));
            chk("t2_nval", 64'(nv[k]), 64'd32);
            chk("t2_index_const", 64'(ib[k]), 64'd0);
        end
        @(negedge clk);
        chk("t2_val_after", 64'(rx_val_a), 64'd0);

        // Flush at bit 10 of the second word with one word queued
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fork
            push3(32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'h5555_AAAA);
            begin
                wait_first(0, lat);
                burst(0, 1'b1, wv[0], iv[0], nv[0], ib[0]);
            end
        join
        chk("t3_first_word", 64'(wv[0]), 64'h0F0F_0F0F);
        @(negedge clk);
        repeat (10) @(negedge clk);
        chk("t3_val_at_bit10", 64'(rx_val_a), 64'd1);
        chk("t3_index_at_bit10", 64'(index_a), 64'd1);
        flush_a = 1'b1; in_valid_a = 1'b1; in_data_a = 32'h7777_7777;
        @(posedge clk);
        @(negedge clk);
        flush_a = 1'b0; in_valid_a = 1'b0;
        chk("t3_val_after_flush", 64'(rx_val_a), 64'd0);
        chk("t3_busy_after_flush", 64'(busy_a), 64'd0);
        chk("t3_ready_after_flush", 64'(in_ready_a), 64'd1);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rx_val_a || busy_a) stray++;
        end
        chk("t3_no_stray_activity", 64'(stray), 64'd0);
        push_word(0, 32'h0000_00F0);
        wait_first(0, lat);
        chk("t3_post_latency", 64'(lat), 64'd1);
        burst(0, 1'b1, wv[0], iv[0], nv[0], ib[0]);
        chk("t3_post_word", 64'(wv[0]), 64'h0000_00F0);
        chk("t3_post_index", 64'(iv[0]), 64'd2);

        // Asynchronous reset mid-burst
        push_word(0, 32'hFFFF_FFFF);
        wait_first(0, lat);
        repeat (5) @(negedge clk);
        chk("t4_pre_index", 64'(index_a), 64'd3);
        chk("t4_pre_data", 64'(rx_data_a), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_rx_val", 64'(rx_val_a), 64'd0);
        chk("t4_rst_rx_data", 64'(rx_data_a), 64'd0);
        chk("t4_rst_index", 64'(index_a), 64'd0);
        chk("t4_rst_busy", 64'(busy_a), 64'd0);
        chk("t4_rst_in_ready", 64'(in_ready_a), 64'd1);
        #4 rst = 1'b1;
        @(negedge clk);
        push_word(0, 32'h1234_5678);
        wait_first(0, lat);
        chk("t4_latency", 64'(lat), 64'd1);
        burst(0, 1'b1, wv[0], iv[0], nv[0], ib[0]);
        chk("t4_word", 64'(wv[0]), 64'h1234_5678);
        chk("t4_index", 64'(iv[0]), 64'd0);
        chk("t4_nval", 64'(nv[0]), 64'd32);

        // LSB first with a 3-cycle gap between words
        @(negedge clk);
        push_word(1, 32'h0000_0003);
        push_word(1, 32'h8000_0001);
        wait_first(1, lat);
        chk("t5_latency", 64'(lat), 64'd0);
        burst(1, 1'b0, wv[0], iv[0], nv[0], ib[0]);
        chk("t5_word0", 64'(wv[0]), 64'h0000_0003);
        chk("t5_index0", 64'(iv[0]), 64'd0);
        chk("t5_nval0", 64'(nv[0]), 64'd32);
        @(negedge clk);
        wait_first(1, gap);
        chk("t5_gap", 64'(gap), 64'd3);
        burst(1, 1'b0, wv[1], iv[1], nv[1], ib[1]);
        chk("t5_word1", 64'(wv[1]), 64'h8000_0001);
        chk("t5_index1", 64'(iv[1]), 64'd1);
        chk("t5_index1_const", 64'(ib[1]), 64'd0);
        repeat (6) @(negedge clk);
        chk("t5_idle_busy", 64'(busy_b), 64'd0);
        chk("t5_idle_val", 64'(rx_val_b), 64'd0);

        // Index wrap from all-ones to zero
        force dut_b.next_index_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut_b.next_index_q;
        push_word(1, 32'h0000_0003);
        push_word(1, 32'hC000_0000);
        wait_first(1, lat);
        burst(1, 1'b0, wv[0], iv[0], nv[0], ib[0]);
        chk("t6_word0", 64'(wv[0]), 64'h0000_0003);
        chk("t6_index_max", 64'(iv[0]), 64'hFFFF_FFFF);
        @(negedge clk);
        wait_first(1, gap);
        chk("t6_gap", 64'(gap), 64'd3);
        burst(1, 1'b0, wv[1], iv[1], nv[1], ib[1]);
        chk("t6_word1", 64'(wv[1]), 64'hC000_0000);
        chk("t6_index_wrap", 64'(iv[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
